// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - Single-outstanding instruction fetch unit with redirect flush and halt
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_FLUSH,
        S_VALID,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] target;
    logic        unused_redirect_lsbs;

    assign target               = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pend_q    <= 32'h0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack && redirect_valid) begin
                    pc_d = target;
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = S_VALID;
                end else if (redirect_valid) begin
                    pend_d  = target;
                    state_d = S_WAIT_FLUSH;
                end
            end
            S_WAIT_FLUSH: begin
                // The stale response is dropped; the newest redirect wins even on the ack cycle.
                if (imem_ack) begin
                    pc_d    = redirect_valid ? target : pend_q;
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    pend_d = target;
                end
            end
            S_VALID: begin
                if (inst_ready) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = redirect_valid ? target : pc_q + PC_STEP;
                        state_d = S_FETCH;
                    end
                end else if (redirect_valid) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req   = (state_q == S_FETCH) || (state_q == S_WAIT_FLUSH);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = (state_q == S_VALID);
    assign halted     = (state_q == S_HALT);

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, 4, sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; word-aligned.
REQ-007 imem_ack  input  1  one-cycle pulse: imem_rdata valid for current request.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 inst  output  32  instruction presented to control_unit.
REQ-010 inst_pc  output  32  PC of inst.
REQ-011 inst_valid  output  1  inst/inst_pc valid.
REQ-012 inst_ready  input  1  downstream consumes inst this cycle.
REQ-013 redirect_valid  input  1  branch/jump target valid this cycle.
REQ-014 redirect_pc  input  32  branch/jump target.
REQ-015 halt  input  1  consumed instruction is ebreak.
REQ-016 halted  output  1  fetch permanently stopped until reset.

Function
REQ-017 States SHALL be IDLE, FETCH, WAIT_FLUSH, VALID, HALT; reset state IDLE.
REQ-018 IDLE SHALL go to FETCH unconditionally next cycle; imem_req low in IDLE.
REQ-019 FETCH: imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-020 FETCH with imem_ack: inst<=imem_rdata, inst_pc<=pc, go VALID; inst_valid high the cycle after ack (1-cycle latency).
REQ-021 VALID: inst_valid SHALL stay 1 and inst/inst_pc stable until handshake (inst_valid && inst_ready).
REQ-022 On handshake with halt=1: go HALT; halt has priority over redirect_valid.
REQ-023 On handshake with redirect_valid=1: pc<=redirect_pc, go FETCH.
REQ-024 On handshake with neither: pc<=pc+PC_STEP (mod 2^32, 32'hFFFF_FFFC wraps to 0), go FETCH.
REQ-025 VALID with redirect_valid=1 and inst_ready=0: held instruction discarded, inst_valid low next cycle, pc<=redirect_pc, go FETCH.
REQ-026 FETCH with redirect_valid=1 and no ack same cycle: latch redirect_pc into pending register, go WAIT_FLUSH; imem_req/imem_addr unchanged.
REQ-027 FETCH with redirect_valid and imem_ack same cycle: returned data discarded, pc<=redirect_pc, stay FETCH with new address next cycle.
REQ-028 WAIT_FLUSH: imem_req held 1 at old address; on imem_ack data discarded, pc<=pending, go FETCH; further redirect_valid overwrites pending.
REQ-029 redirect_valid in IDLE or HALT SHALL be ignored.
REQ-030 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-031 HALT: imem_req=0, inst_valid=0, halted=1; left only by rst.
REQ-032 imem_ack outside FETCH/WAIT_FLUSH SHALL be ignored.
REQ-033 inst_valid SHALL never be 1 in IDLE, FETCH, WAIT_FLUSH, HALT.

Reset
REQ-034 rst asserted SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0, halted=0, pending=0.
REQ-035 rst mid-request SHALL abandon the outstanding fetch; an imem_ack arriving in IDLE is ignored.

Verification
REQ-036 Reset release, memory acks each request after 2 cycles with 32'h0010_0093 -> imem_addr 8000_0000, 8000_0004, 8000_0008; inst_pc matches; inst_valid 1 cycle after each ack.
REQ-037 inst_ready held low 5 cycles in VALID -> inst/inst_pc/inst_valid stable, imem_req low, pc not advanced.
REQ-038 Handshake at pc 8000_0010 with redirect_valid=1, redirect_pc=8000_0103 -> next imem_addr 8000_0100.
REQ-039 redirect_valid (target 8000_0200) during FETCH 3 cycles before ack -> returned word never on inst_valid; next imem_addr 8000_0200.
REQ-040 Handshake with halt=1 and redirect_valid=1 -> halted=1, imem_req=0 forever; rst restores fetch at 8000_0000.
REQ-041 pc forced to FFFF_FFFC via redirect, consumed without redirect -> next imem_addr 0000_0000.
